index_buff_reader: RTL and testbench

//  Downstream stage of the index-buffer write controller. Once a tile of sparse indices is written into the
//  Ram_Row index BRAMs, this block reads all rows in lock-step, one shared address per cycle. It returns
//  one Ram_Row-wide index beat per address to the sparse PE array over a valid/ready handshake.
//  A 2-entry skid FIFO absorbs the 1-cycle BRAM read latency, so backpressure never drops data.

---
 rtl/index_buff_reader.sv | 138 +++++++++++++
 tb/tb_index_buff_reader.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/index_buff_reader.sv
// Lock-step multi-row index BRAM reader with a 2-entry skid FIFO toward the PE array.
// Optional feature macro ROW_MASK_EN adds a per-row read mask latched at start.
module index_buff_reader #(
    parameter int Ram_Row         = 16,
    parameter int Read_Addr_Width = 11,
    parameter int Read_Data_Width = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [Read_Addr_Width+4:0]           Addr_end,
`ifdef ROW_MASK_EN
    input  logic [Ram_Row-1:0]                   row_mask,
`endif
    output logic [Read_Addr_Width*Ram_Row-1:0]   addrout_row,
    output logic [Ram_Row-1:0]                   enb_row,
    input  logic [Read_Data_Width*Ram_Row-1:0]   datain_row,
    output logic [Read_Data_Width*Ram_Row-1:0]   dataout,
    output logic                                 dout_valid,
    input  logic                                 dout_ready,
    output logic                                 busy,
    output logic                                 finished
);
    localparam int AW = Read_Addr_Width;
    localparam int RW = Read_Data_Width;
    localparam int DW = Read_Data_Width * Ram_Row;
    localparam logic [AW-1:0] ONE = 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [AW-1:0]      rd_addr;
    logic [AW-1:0]      depth;
    logic [Ram_Row-1:0] mask;
    logic               inflight;
    logic [1:0]         fifo_cnt;
    logic [DW-1:0]      head;
    logic [DW-1:0]      tail;
    logic [DW-1:0]      din;
    logic               pop;
    logic               push;
    logic               room;
    logic               issue;
    logic               last;
    logic               accept;

    assign accept = (state == IDLE) && start;
    assign pop    = dout_valid & dout_ready;
    assign push   = inflight;

    // A read is only launched if its data is guaranteed a FIFO slot.
    assign room   = ({1'b0, fifo_cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
    assign issue  = (state == READ) && (depth != '0) && room;
    assign last   = (rd_addr == depth - ONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if ((depth == '0) || (issue && last)) state_nxt = DRAIN;
            DRAIN:   if (!inflight && (fifo_cnt == {1'b0, pop})) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_addr  <= '0;
            depth    <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (accept) begin
                depth   <= Addr_end[AW+3:4];
                rd_addr <= '0;
            end else if (issue) begin
                rd_addr <= rd_addr + ONE;
            end
        end
    end

`ifdef ROW_MASK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '0;
        end else if (accept) begin
            mask <= row_mask;
        end
    end
`else
    assign mask = '1;
`endif

    always_comb begin
        din = datain_row;
        for (int r = 0; r < Ram_Row; r++) begin
            if (!mask[r]) din[r*RW +: RW] = '0;
        end
    end

    // Head register feeds dataout directly; tail only holds the skid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= 2'd0;
            head     <= '0;
            tail     <= '0;
        end else if (push && pop) begin
            if (fifo_cnt == 2'd2) begin
                head <= tail;
                tail <= din;
            end else begin
                head <= din;
            end
        end else if (push) begin
            if (fifo_cnt == 2'd0) head <= din;
            else                  tail <= din;
            fifo_cnt <= fifo_cnt + 2'd1;
        end else if (pop) begin
            head     <= tail;
            fifo_cnt <= fifo_cnt - 2'd1;
        end
    end

    assign dataout     = head;
    assign dout_valid  = (fifo_cnt != 2'd0);
    assign busy        = (state != IDLE);
    assign finished    = (state == DONE);
    assign enb_row     = issue ? mask : '0;
    assign addrout_row = issue ? {Ram_Row{rd_addr}} : '0;

endmodule

// File: tb/tb_index_buff_reader.sv
// Randomised self-checking bench for index_buff_reader with a BRAM model and beat scoreboard.
// Build with ROW_MASK_EN defined to also exercise the row mask.
module tb_index_buff_reader;
    localparam int R  = 16;
    localparam int AW = 11;
    localparam int RW = 64;
    localparam int DW = R * RW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [AW+4:0]   Addr_end;
`ifdef ROW_MASK_EN
    logic [R-1:0]    row_mask;
`endif
    logic [AW*R-1:0] addrout_row;
    logic [R-1:0]    enb_row;
    logic [DW-1:0]   datain_row;
    logic [DW-1:0]   dataout;
    logic            dout_valid;
    logic            dout_ready;
    logic            busy;
    logic            finished;

    index_buff_reader #(
        .Ram_Row(R), .Read_Addr_Width(AW), .Read_Data_Width(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Addr_end(Addr_end),
`ifdef ROW_MASK_EN
        .row_mask(row_mask),
`endif
        .addrout_row(addrout_row), .enb_row(enb_row), .datain_row(datain_row),
        .dataout(dataout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .busy(busy), .finished(finished)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]   tile_seed = 32'h1234_5678;
    logic [R-1:0]  mask_exp = '1;

    int            issue_addr[$];
    int            issue_t[$];
    int            acc_t[$];
    logic [DW-1:0] beats[$];
    bit            busy_q[$];
    int            fin_t;
    int            fin_n;
    int            stall_err;
    int            slice_err;
    int            enb_err;
    int            inv_err;
    int            reset_err;
    bit            timeout;

    function automatic logic [RW-1:0] word(input logic [31:0] s, input int r,
                                           input logic [AW-1:0] a);
        return {s, 8'(r), 13'd0, a};
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int k);
        logic [DW-1:0] b;
        b = '0;
        for (int r = 0; r < R; r++)
            if (mask_exp[r]) b[r*RW +: RW] = word(tile_seed, r, AW'(k));
        return b;
    endfunction

    function automatic bit ready_at(input int mode, input int t, input int sn);
        case (mode)
            0:       return 1'b1;
            1:       return (t % 2) == 0;
            2:       return t >= sn;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // BRAM: registered read, output held when not enabled
    always @(posedge clk) begin
        for (int r = 0; r < R; r++)
            if (enb_row[r])
                datain_row[r*RW +: RW] <= word(tile_seed, r, addrout_row[r*AW +: AW]);
    end

    task automatic run_tile(input logic [AW+4:0] ae, input int mode, input int sn,
                            input int abort_beats, input int restart_at, input int budget);
        logic [DW-1:0] prev_d;
        bit prev_stall;
        int t;
        issue_addr.delete(); issue_t.delete(); acc_t.delete();
        beats.delete(); busy_q.delete();
        fin_t = -1; fin_n = 0; stall_err = 0; slice_err = 0;
        enb_err = 0; inv_err = 0; reset_err = 0; timeout = 0;
        @(posedge clk); #1;
        tile_seed = $urandom();
        Addr_end = ae;
        start = 1'b1;
        dout_ready = ready_at(mode, 0, sn);
        prev_stall = 0;
        prev_d = '0;
        t = 0;
        forever begin
            @(negedge clk);
            if (enb_row != '0) begin
                issue_addr.push_back(int'(addrout_row[AW-1:0]));
                issue_t.push_back(t);
                if (enb_row !== mask_exp) enb_err++;
                for (int r = 1; r < R; r++)
                    if (addrout_row[r*AW +: AW] !== addrout_row[AW-1:0]) slice_err++;
            end else if (addrout_row !== '0) begin
                enb_err++;
            end
            if (prev_stall && (!dout_valid || dataout !== prev_d)) stall_err++;
            prev_stall = dout_valid && !dout_ready;
            prev_d = dataout;
            if (dout_valid && dout_ready) begin
                beats.push_back(dataout);
                acc_t.push_back(t);
            end
            busy_q.push_back(busy);
            if (finished) begin
                fin_n++;
                if (fin_t < 0) fin_t = t;
            end
            if (int'(dut.fifo_cnt) + int'(dut.inflight) > 2) inv_err++;
            if (abort_beats > 0 && beats.size() == abort_beats) begin
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                if ({enb_row, addrout_row, dataout, dout_valid, busy, finished} !== '0)
                    reset_err++;
                if (finished) fin_n++;
                break;
            end
            if (fin_t >= 0 && t >= fin_t + 2) break;
            if (t >= budget) begin
                timeout = 1;
                break;
            end
            @(posedge clk); #1;
            t++;
            start = (t == restart_at);
            if (t == restart_at) Addr_end = AW'($urandom_range(32, 200)) << 4;
            dout_ready = ready_at(mode, t, sn);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        Addr_end = '0;
        dout_ready = 1'b0;
`ifdef ROW_MASK_EN
        row_mask = '1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (enb_row !== '0) begin
            n_errors++; $display("FAIL reset_enb: got %h want 0", enb_row);
        end
        n_checks++;
        if (addrout_row !== '0) begin
            n_errors++; $display("FAIL reset_addr: got nonzero want 0");
        end
        n_checks++;
        if ({dout_valid, busy, finished} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags: got %b want 000", {dout_valid, busy, finished});
        end
        n_checks++;
        if (dataout !== '0) begin
            n_errors++; $display("FAIL reset_data: got nonzero want 0");
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int bad;
        run_tile(16'd64, 0, 0, 0, 0, 40);
        n_checks++;
        if (timeout) begin
            n_errors++; $display("FAIL basic_timeout: got timeout want finished");
        end
        n_checks++;
        if (issue_addr.size() != 4) begin
            n_errors++; $display("FAIL basic_issues: got %0d want 4", issue_addr.size());
        end
        bad = 0;
        foreach (issue_addr[i])
            if (issue_addr[i] != i || issue_t[i] != i + 1) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL basic_addr_seq: got %0d bad want 0", bad);
        end
        bad = 0;
        foreach (beats[i])
            if (beats[i] !== exp_beat(i) || acc_t[i] != i + 3) bad++;
        n_checks++;
        if (bad != 0 || beats.size() != 4) begin
            n_errors++; $display("FAIL basic_beats: got %0d bad of %0d want 0 of 4", bad, beats.size());
        end
        n_checks++;
        if (acc_t.size() == 4 && fin_t != acc_t[3] + 1) begin
            n_errors++; $display("FAIL basic_finish: got t=%0d want %0d", fin_t, acc_t[3] + 1);
        end
        n_checks++;
        if (fin_n != 1) begin
            n_errors++; $display("FAIL basic_fin_pulses: got %0d want 1", fin_n);
        end
        bad = 0;
        foreach (busy_q[i])
            if (busy_q[i] != (i >= 1 && i <= fin_t)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL basic_busy: got %0d bad cycles want 0", bad);
        end
        n_checks++;
        if (enb_err + slice_err + inv_err != 0) begin
            n_errors++; $display("FAIL basic_bus: got %0d/%0d/%0d want 0", enb_err, slice_err, inv_err);
        end
    endtask

    task automatic test_toggle;
        int bad;
        run_tile(16'd128, 1, 0, 0, 0, 80);
        bad = 0;
        foreach (beats[i]) if (beats[i] !== exp_beat(i)) bad++;
        n_checks++;
        if (timeout || bad != 0 || beats.size() != 8) begin
            n_errors++; $display("FAIL toggle_beats: got %0d bad of %0d want 0 of 8", bad, beats.size());
        end
        n_checks++;
        if (stall_err != 0) begin
            n_errors++; $display("FAIL toggle_hold: got %0d changes want 0", stall_err);
        end
        n_checks++;
        if (fin_n != 1 || inv_err != 0) begin
            n_errors++; $display("FAIL toggle_fin: got %0d pulses %0d inv want 1 0", fin_n, inv_err);
        end
    endtask

    task automatic test_stall;
        int bad;
        int during;
        run_tile(16'd64, 2, 10, 0, 0, 60);
        during = 0;
        foreach (issue_t[i]) if (issue_t[i] < 10) during++;
        n_checks++;
        if (during != 2) begin
            n_errors++; $display("FAIL stall_issues: got %0d want 2", during);
        end
        bad = 0;
        foreach (beats[i]) if (beats[i] !== exp_beat(i)) bad++;
        n_checks++;
        if (timeout || bad != 0 || beats.size() != 4) begin
            n_errors++; $display("FAIL stall_beats: got %0d bad of %0d want 0 of 4", bad, beats.size());
        end
        n_checks++;
        if (stall_err != 0 || inv_err != 0) begin
            n_errors++; $display("FAIL stall_hold: got %0d/%0d want 0", stall_err, inv_err);
        end
    endtask

    task automatic test_empty;
        run_tile(16'd15, 0, 0, 0, 0, 20);
        n_checks++;
        if (issue_addr.size() != 0) begin
            n_errors++; $display("FAIL empty_issues: got %0d want 0", issue_addr.size());
        end
        n_checks++;
        if (fin_t != 3 || fin_n != 1) begin
            n_errors++; $display("FAIL empty_finish: got t=%0d n=%0d want t=3 n=1", fin_t, fin_n);
        end
        n_checks++;
        if (beats.size() != 0) begin
            n_errors++; $display("FAIL empty_beats: got %0d want 0", beats.size());
        end
    endtask

    task automatic test_abort;
        int bad;
        run_tile(16'd96, 0, 0, 3, 0, 40);
        n_checks++;
        if (reset_err != 0) begin
            n_errors++; $display("FAIL abort_outputs: got nonzero want 0");
        end
        n_checks++;
        if (fin_n != 0) begin
            n_errors++; $display("FAIL abort_finish: got %0d want 0", fin_n);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (dout_valid || busy || enb_row != '0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL abort_idle: got %0d active cycles want 0", bad);
        end
        run_tile(16'd96, 0, 0, 0, 0, 40);
        bad = 0;
        foreach (issue_addr[i]) if (issue_addr[i] != i) bad++;
        foreach (beats[i]) if (beats[i] !== exp_beat(i)) bad++;
        n_checks++;
        if (timeout || bad != 0 || beats.size() != 6 || issue_addr.size() != 6) begin
            n_errors++; $display("FAIL abort_replay: got %0d bad %0d beats want 0 6", bad, beats.size());
        end
    endtask

`ifdef ROW_MASK_EN
    task automatic test_mask;
        int bad;
        row_mask = 16'h00FF;
        mask_exp = 16'h00FF;
        run_tile(16'd32, 0, 0, 0, 0, 30);
        n_checks++;
        if (enb_err != 0 || issue_addr.size() != 2) begin
            n_errors++; $display("FAIL mask_enb: got %0d errs %0d issues want 0 2", enb_err, issue_addr.size());
        end
        bad = 0;
        foreach (beats[i])
            if (beats[i] !== exp_beat(i) || beats[i][DW-1:8*RW] !== '0) bad++;
        n_checks++;
        if (bad != 0 || beats.size() != 2) begin
            n_errors++; $display("FAIL mask_data: got %0d bad of %0d want 0 of 2", bad, beats.size());
        end
        row_mask = '1;
        mask_exp = '1;
    endtask
`endif

    task automatic test_random;
        int bad;
        int d;
        int mode;
        logic [AW+4:0] ae;
        for (int n = 0; n < 8; n++) begin
            d = $urandom_range(0, 12);
            mode = $urandom_range(0, 3);
            ae = {1'($urandom_range(0, 1)), AW'(d), 4'($urandom_range(0, 15))};
            run_tile(ae, mode, $urandom_range(2, 8), 0, $urandom_range(2, 3), 60 + 12 * d);
            bad = 0;
            foreach (issue_addr[i]) if (issue_addr[i] != i) bad++;
            foreach (beats[i]) if (beats[i] !== exp_beat(i)) bad++;
            n_checks++;
            if (timeout || bad != 0 || beats.size() != d || issue_addr.size() != d) begin
                n_errors++;
                $display("FAIL rand_beats[%0d]: got %0d bad %0d beats want 0 %0d", n, bad, beats.size(), d);
            end
            n_checks++;
            if (fin_n != 1 || fin_t != (d == 0 ? 3 : acc_t[acc_t.size()-1] + 1)) begin
                n_errors++; $display("FAIL rand_finish[%0d]: got t=%0d n=%0d", n, fin_t, fin_n);
            end
            bad = stall_err + inv_err + enb_err + slice_err;
            foreach (busy_q[i]) if (busy_q[i] != (i >= 1 && i <= fin_t)) bad++;
            n_checks++;
            if (bad != 0) begin
                n_errors++; $display("FAIL rand_proto[%0d]: got %0d violations want 0", n, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_empty();
        test_abort();
`ifdef ROW_MASK_EN
        test_mask();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
